// File: rtl/par_int_host_8bit.sv
// Host-side initiator for the 8-bit parallel interface.
// Accepts single write/read commands on a valid/ready port, drives the bus
// direction (w_r) and host data (di_o), samples device data (do_i) and returns
// read data on a one-cycle response strobe.
//
// Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready
// are both 1; cmd_ready is high only while idle and out of reset, so cmd_valid
// seen while busy is simply ignored (no queueing). rsp_valid is a one-cycle
// pulse with no back-pressure; rsp_data holds until the next read completes.
module par_int_host_8bit #(
  parameter int HOLD_CYC = 2,
  parameter int RD_WAIT  = 2,
  parameter int TURN     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       w_r,
  output logic [7:0] di_o,
  input  logic [7:0] do_i,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TURN_ST    = 2'd1,
    WR_HOLD    = 2'd2,
    RD_WAIT_ST = 2'd3
  } state_t;

  // Phase counters are loaded with N-1 and the phase ends when they reach 0.
  localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RDW_M1  = 4'(RD_WAIT - 1);
  localparam logic [3:0] TURN_M1 = 4'(TURN - 1);
  localparam logic       HAS_TURN = (TURN > 0);

  state_t     state;
  logic [3:0] cnt;
  logic       wr_l;
  logic [7:0] data_l;

  // Ready is gated by rst so it reads 0 during reset and 1 in the first
  // cycle after it, without waiting for a register to update.
  assign cmd_ready = (state == IDLE) && !rst;
  assign dbg_state = state;

  // Command FSM; all bus-facing outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_l      <= 1'b1;
      data_l    <= 8'h00;
      w_r       <= 1'b1;
      di_o      <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            wr_l   <= cmd_wr;
            data_l <= cmd_data;
            w_r    <= cmd_wr;
            if ((cmd_wr != w_r) && HAS_TURN) begin
              state <= TURN_ST;
              cnt   <= TURN_M1;
            end else if (cmd_wr) begin
              state <= WR_HOLD;
              cnt   <= HOLD_M1;
              di_o  <= cmd_data;
            end else begin
              state <= RD_WAIT_ST;
              cnt   <= RDW_M1;
            end
          end
        end
        TURN_ST: begin
          if (cnt == 4'd0) begin
            if (wr_l) begin
              state <= WR_HOLD;
              cnt   <= HOLD_M1;
              di_o  <= data_l;
            end else begin
              state <= RD_WAIT_ST;
              cnt   <= RDW_M1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_HOLD: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
            di_o  <= 8'h00;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RD_WAIT_ST: begin
          if (cnt == 4'd0) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_data  <= do_i;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_par_int_host_8bit.sv
// Directed bench for par_int_host_8bit with default parameters.
// Inputs change 1ns after each rising edge; outputs are sampled at the same
// point, before new inputs are applied, so each sample shows the cycle that
// follows the edge.
module tb_par_int_host_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       w_r;
  logic [7:0] di_o;
  logic [7:0] do_i;
  logic [1:0] dbg_state;

  int errs   = 0;
  int checks = 0;

  par_int_host_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .w_r       (w_r),
    .di_o      (di_o),
    .do_i      (do_i),
    .dbg_state (dbg_state)
  );

  // Clock and a hard time limit
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded, required finish before 100us");
    $fatal(1);
  end

  // Advance to 1ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b1; cmd_data = 8'h00; do_i = 8'h00;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (w_r !== 1'b1 || di_o !== 8'h00 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 || cmd_ready !== 1'b0) begin
        errs++;
        $display("FAIL reset_hold[%0d]: w_r=%b di_o=%h rsp_valid=%b rsp_data=%h ready=%b, want 1 00 0 00 0",
                 k, w_r, di_o, rsp_valid, rsp_data, cmd_ready);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || w_r !== 1'b1 || di_o !== 8'h00 || rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
      errs++;
      $display("FAIL reset_release: ready=%b w_r=%b di_o=%h rsp_valid=%b rsp_data=%h, want 1 1 00 0 00",
               cmd_ready, w_r, di_o, rsp_valid, rsp_data);
    end
  endtask

  // Write D6 with no turnaround; caller leaves us in an idle cycle
  task automatic test_write();
    logic [7:0] exp_di;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_data = 8'hD6;
    for (int k = 1; k <= 3; k++) begin
      step();
      cmd_valid = 1'b0;
      exp_di = (k <= 2) ? 8'hD6 : 8'h00;
      checks++;
      if (di_o !== exp_di || w_r !== 1'b1 || cmd_ready !== (k == 3) || rsp_valid !== 1'b0) begin
        errs++;
        $display("FAIL write_A+%0d: di_o=%h w_r=%b ready=%b rsp_valid=%b, want %h 1 %b 0",
                 k, di_o, w_r, cmd_ready, rsp_valid, exp_di, (k == 3));
      end
    end
  endtask

  // Read after write: one turnaround cycle, response in A+4
  task automatic test_read_after_write();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_data = 8'h99; do_i = 8'hFF;
    for (int k = 1; k <= 4; k++) begin
      step();
      cmd_valid = 1'b0;
      checks++;
      if (w_r !== 1'b0 || di_o !== 8'h00 || rsp_valid !== (k == 4) || cmd_ready !== (k == 4)) begin
        errs++;
        $display("FAIL read_A+%0d: w_r=%b di_o=%h rsp_valid=%b ready=%b, want 0 00 %b %b",
                 k, w_r, di_o, rsp_valid, cmd_ready, (k == 4), (k == 4));
      end
    end
    checks++;
    if (rsp_data !== 8'hFF) begin
      errs++;
      $display("FAIL read_data: rsp_data=%h, want ff", rsp_data);
    end
  endtask

  // Two reads with cmd_valid held; second accepted in the first rsp_valid cycle
  task automatic test_back_to_back();
    logic       exp_v;
    logic [7:0] exp_d;
    cmd_valid = 1'b1; cmd_wr = 1'b0; do_i = 8'h5A;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_v = (k == 3) || (k == 6);
      exp_d = (k == 6) ? 8'hA5 : 8'h5A;
      checks++;
      if (rsp_valid !== exp_v || w_r !== 1'b0 || di_o !== 8'h00 || (exp_v && rsp_data !== exp_d)) begin
        errs++;
        $display("FAIL b2b_A+%0d: rsp_valid=%b rsp_data=%h w_r=%b di_o=%h, want %b %h 0 00",
                 k, rsp_valid, rsp_data, w_r, di_o, exp_v, exp_d);
      end
      if (k == 3) do_i = 8'hA5;
      if (k == 5) cmd_valid = 1'b0;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL b2b_ready: ready=%b, want 1", cmd_ready);
    end
  endtask

  // Write 81 after reads (turnaround), cmd_valid toggles and cmd_data changes while busy
  task automatic test_busy_ignore();
    logic [7:0] exp_di;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_data = 8'h81;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_di = (k == 2 || k == 3) ? 8'h81 : 8'h00;
      checks++;
      if (di_o !== exp_di || w_r !== 1'b1 || cmd_ready !== (k >= 4) || rsp_valid !== 1'b0) begin
        errs++;
        $display("FAIL busy_A+%0d: di_o=%h w_r=%b ready=%b rsp_valid=%b, want %h 1 %b 0",
                 k, di_o, w_r, cmd_ready, rsp_valid, exp_di, (k >= 4));
      end
      cmd_data  = 8'hFF;
      cmd_wr    = k[0];
      cmd_valid = (k <= 3) ? k[0] : 1'b0;
    end
  endtask

  // Reset in A+2 of a read aborts it; a following write completes
  task automatic test_reset_abort();
    logic [7:0] exp_di;
    cmd_valid = 1'b1; cmd_wr = 1'b0; do_i = 8'h77;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (w_r !== 1'b0) begin
      errs++;
      $display("FAIL abort_A+1: w_r=%b, want 0", w_r);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (w_r !== 1'b1 || di_o !== 8'h00 || rsp_data !== 8'h00 || rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL abort_after_rst: w_r=%b di_o=%h rsp_data=%h rsp_valid=%b, want 1 00 00 0",
               w_r, di_o, rsp_data, rsp_valid);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errs++;
        $display("FAIL abort_quiet[%0d]: rsp_valid=%b ready=%b, want 0 1", k, rsp_valid, cmd_ready);
      end
    end
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_data = 8'h3C;
    for (int k = 1; k <= 3; k++) begin
      step();
      cmd_valid = 1'b0;
      exp_di = (k <= 2) ? 8'h3C : 8'h00;
      checks++;
      if (di_o !== exp_di || w_r !== 1'b1 || cmd_ready !== (k == 3)) begin
        errs++;
        $display("FAIL post_abort_write_A+%0d: di_o=%h w_r=%b ready=%b, want %h 1 %b",
                 k, di_o, w_r, cmd_ready, exp_di, (k == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_after_write();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/par_int_host_8bit.md
# par_int_host_8bit

Host-side initiator for the 8-bit parallel interface. It drives the direction line `w_r` and the host-to-device data bus `di_o`, and captures the device-to-host bus `do_i`. It takes single write/read commands from a local valid/ready port and returns read data on a one-cycle response strobe. It sits between on-chip logic and `top_par_int_8bit`, replacing the hand-driven stimulus used so far.

## Interface
Parameters:
- `HOLD_CYC`, default 2: cycles write data is held on `di_o`; legal range 1..15.
- `RD_WAIT`, default 2: cycles `w_r`=0 is held before `do_i` is sampled; legal range 1..15.
- `TURN`, default 1: idle turnaround cycles inserted when the bus direction changes; legal range 0..15.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: host idle; a command is accepted on `cmd_valid && cmd_ready`.
- `cmd_wr` in 1: 1 = write, 0 = read.
- `cmd_data` in 8: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle pulse carrying read data.
- `rsp_data` out 8: captured read data; held until the next read completes.
- `w_r` out 1: bus direction; 1 = write (host drives), 0 = read (device drives).
- `di_o` out 8: host-to-device data.
- `do_i` in 8: device-to-host data; meaningful only while `w_r`=0.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1.
  - TURN_ST: direction changed; counts `TURN` cycles.
  - WR_HOLD: `di_o` = latched data; counts `HOLD_CYC` cycles.
  - RD_WAIT_ST: counts `RD_WAIT` cycles, then samples `do_i`.
- Reset values: `cmd_ready`=0 during reset and 1 from the first cycle after reset. `rsp_valid`=0, `rsp_data`=8'h00, `w_r`=1, `di_o`=8'h00, state IDLE.
- Transitions out of IDLE on acceptance:
  - If `cmd_wr` ≠ current `w_r` and `TURN`>0, go to TURN_ST.
  - Otherwise go directly to WR_HOLD (write) or RD_WAIT_ST (read).
  - TURN_ST, after `TURN` cycles, goes to WR_HOLD or RD_WAIT_ST.
- `w_r` is a register. It updates in the cycle after acceptance and holds its last value while idle; the bus is never released between commands.
- `di_o` is 8'h00 whenever the state is not WR_HOLD, including TURN_ST and every cycle with `w_r`=0. This matches the device's gated-bus convention.
- `cmd_data` and `cmd_wr` are latched at acceptance; later changes are ignored.
- `cmd_valid` is ignored while `cmd_ready`=0. There is no queueing.
- Counter: 4 bits, loaded with N−1 on phase entry, phase ends at 0. Parameters outside the legal ranges are unsupported.
- Completion:
  - The last WR_HOLD or RD_WAIT_ST cycle returns the FSM to IDLE.
  - A read completion registers `do_i` into `rsp_data` and sets `rsp_valid` for exactly one cycle.
- Reset asserted mid-command aborts it:
  - No `rsp_valid` is issued.
  - `w_r` returns to 1 and `di_o` to 8'h00 in the cycle after the reset edge.
  - `rsp_data` clears.

## Timing
Let A be the acceptance cycle. "Turn" means `TURN` if the direction changed, otherwise 0.
- `w_r` takes the command direction in cycle A+1.
- Write: `di_o`=data in cycles A+turn+1 .. A+turn+`HOLD_CYC`. `di_o`=8'h00 and `cmd_ready`=1 in cycle A+turn+`HOLD_CYC`+1.
- Read:
  - `do_i` is sampled on the edge ending cycle A+turn+`RD_WAIT`.
  - `rsp_valid`=1 and `rsp_data` valid in cycle A+turn+`RD_WAIT`+1.
  - `cmd_ready`=1 in that same cycle.
- Back-to-back: a command presented while `cmd_ready`=1 is accepted immediately, including in the `rsp_valid` cycle. Same-direction commands need no idle gap.
- Minimum latency (defaults):
  - Same-direction write: 3 cycles acceptance-to-ready.
  - Read after write: 4 cycles acceptance-to-`rsp_valid`.

## Test plan
All scenarios use default parameters.
- Reset release: hold `rst` 2 cycles -> `w_r`=1, `di_o`=00, `rsp_valid`=0, `rsp_data`=00 throughout; `cmd_ready`=1 in the first cycle after reset.
- Write 8'hD6 after reset (no turn) -> `di_o`=D6 in A+1 and A+2; `di_o`=00 and `cmd_ready`=1 in A+3; `w_r` stays 1.
- Read following the write, `do_i`=8'hFF -> `w_r`=0 from A+1; `di_o`=00 throughout; `rsp_valid`=1 with `rsp_data`=FF in A+4 only.
- Back-to-back reads (8'h5A then 8'hA5 on `do_i`), second `cmd_valid` held high -> second accepted in the first `rsp_valid` cycle; responses 5A then A5, 3 cycles apart; no turnaround.
- `cmd_valid` toggling while busy, with `cmd_data` changed mid-write -> exactly one command executes, with the originally latched data.
- Reset asserted in cycle A+2 of a read -> no `rsp_valid`; `w_r`=1, `di_o`=00, `rsp_data`=00 next cycle; a subsequent write 8'h3C completes normally.
